// File: rtl/hilo_unit.sv
// hilo_unit: multiply/divide unit holding the HI/LO register pair for the E stage.
// Define HILO_DELAY_EN for multi-cycle latency (mult 5, div 10); otherwise results commit at the start edge.
module hilo_unit (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [3:0]  HILOtype,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic        busy,
    output logic [31:0] out,
    output logic [31:0] HI,
    output logic [31:0] LO
);
    // state | meaning
    // IDLE  | accepting instructions; mthi/mtlo write directly
    // BUSY  | mult/div in flight, cnt counts down to commit
    localparam logic [3:0] OP_MULT  = 4'd1;
    localparam logic [3:0] OP_MULTU = 4'd2;
    localparam logic [3:0] OP_DIV   = 4'd3;
    localparam logic [3:0] OP_DIVU  = 4'd4;
    localparam logic [3:0] OP_MFHI  = 4'd5;
    localparam logic [3:0] OP_MFLO  = 4'd6;
    localparam logic [3:0] OP_MTHI  = 4'd7;
    localparam logic [3:0] OP_MTLO  = 4'd8;

    logic signed [63:0] prod_s;
    logic [63:0]        prod_u;
    logic [31:0]        mag_a, mag_b, div_b_s, div_b_u;
    logic [31:0]        quo_mag, rem_mag, quo_s, rem_s;
    logic [31:0]        hi_res, lo_res;
    logic               is_arith;
    logic               is_mult;

    assign prod_s = $signed({{32{A[31]}}, A}) * $signed({{32{B[31]}}, B});
    assign prod_u = {32'd0, A} * {32'd0, B};

    // Signed divide works on magnitudes so 0x80000000 / -1 wraps cleanly to 0x80000000.
    assign mag_a   = A[31] ? (~A + 32'd1) : A;
    assign mag_b   = B[31] ? (~B + 32'd1) : B;
    assign div_b_s = (B == 32'd0) ? 32'd1 : mag_b;
    assign div_b_u = (B == 32'd0) ? 32'd1 : B;
    assign quo_mag = mag_a / div_b_s;
    assign rem_mag = mag_a % div_b_s;
    assign quo_s   = (A[31] ^ B[31]) ? (~quo_mag + 32'd1) : quo_mag;
    assign rem_s   = A[31] ? (~rem_mag + 32'd1) : rem_mag;

    assign is_mult = (HILOtype == OP_MULT) || (HILOtype == OP_MULTU);

    // Divide by zero resolves to the current HI/LO, so the commit leaves them unchanged.
    always_comb begin
        hi_res   = HI;
        lo_res   = LO;
        is_arith = 1'b0;
        case (HILOtype)
            OP_MULT: begin
                is_arith         = 1'b1;
                {hi_res, lo_res} = prod_s;
            end
            OP_MULTU: begin
                is_arith         = 1'b1;
                {hi_res, lo_res} = prod_u;
            end
            OP_DIV: begin
                is_arith = 1'b1;
                if (B != 32'd0) begin
                    hi_res = rem_s;
                    lo_res = quo_s;
                end
            end
            OP_DIVU: begin
                is_arith = 1'b1;
                if (B != 32'd0) begin
                    hi_res = A % div_b_u;
                    lo_res = A / div_b_u;
                end
            end
            default: ;
        endcase
    end

    always_comb begin
        case (HILOtype)
            OP_MFHI: out = HI;
            OP_MFLO: out = LO;
            default: out = 32'd0;
        endcase
    end

`ifdef HILO_DELAY_EN
    localparam logic [3:0] MULT_CYC = 4'd5;
    localparam logic [3:0] DIV_CYC  = 4'd10;

    typedef enum logic {IDLE, BUSY} state_t;

    state_t      state;
    logic [3:0]  cnt;
    logic [31:0] hi_tmp, lo_tmp;

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= IDLE;
            cnt    <= 4'd0;
            busy   <= 1'b0;
            HI     <= 32'd0;
            LO     <= 32'd0;
            hi_tmp <= 32'd0;
            lo_tmp <= 32'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        if (is_arith) begin
                            hi_tmp <= hi_res;
                            lo_tmp <= lo_res;
                            cnt    <= is_mult ? MULT_CYC : DIV_CYC;
                            state  <= BUSY;
                            busy   <= 1'b1;
                        end else if (HILOtype == OP_MTHI) begin
                            HI <= A;
                        end else if (HILOtype == OP_MTLO) begin
                            LO <= A;
                        end
                    end
                end
                BUSY: begin
                    // start is ignored here; the hazard unit never issues one legally
                    if (cnt == 4'd1) begin
                        HI    <= hi_tmp;
                        LO    <= lo_tmp;
                        cnt   <= 4'd0;
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
            endcase
        end
    end
`else
    assign busy = 1'b0;

    always_ff @(posedge clk) begin
        if (reset) begin
            HI <= 32'd0;
            LO <= 32'd0;
        end else if (start) begin
            if (is_arith) begin
                HI <= hi_res;
                LO <= lo_res;
            end else if (HILOtype == OP_MTHI) begin
                HI <= A;
            end else if (HILOtype == OP_MTLO) begin
                LO <= A;
            end
        end
    end
`endif

endmodule

// File: doc/hilo_unit.md
# hilo_unit

Multiply/divide unit with the HI/LO register pair, sitting in the E stage of the five-stage pipeline. It executes the eight HI/LO instructions flagged by the controller's `isHILO`/`HILOtype` outputs. It models multi-cycle latency through a `busy` flag that the hazard unit uses to stall. For `mfhi`/`mflo` it returns HI or LO so the value can be carried down the pipe for write-back through the `MemtoReg_HILO` path.

## Interface
- No parameters; latencies are fixed: MULT_CYC = 5, DIV_CYC = 10.
- `clk` input 1: single clock, rising edge.
- `reset` input 1: synchronous, active-high.
- `start` input 1: E-stage instruction is a valid HILO instruction (`isHILO` of the E-stage instruction); sampled at the rising edge.
- `HILOtype` input 4: 0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mfhi, 6 mflo, 7 mthi, 8 mtlo.
- `A` input 32: forwarded rs value.
- `B` input 32: forwarded rt value.
- `busy` output 1: an operation is in flight.
- `out` output 32: HI for mfhi, LO for mflo, otherwise 0; combinational.
- `HI`, `LO` output 32 each: architectural registers, for debug.

## Operation
- FSM has two states, IDLE and BUSY, plus a 4-bit down-counter `cnt`.
- **IDLE + start + mult/multu/div/divu**
  - Compute the result from A and B and latch it into `hi_tmp`/`lo_tmp`.
  - Load `cnt` with MULT_CYC (mult/multu) or DIV_CYC (div/divu), then go to BUSY.
- **BUSY**
  - Decrement `cnt` on every edge.
  - On the edge where `cnt == 1`: commit `hi_tmp`→HI and `lo_tmp`→LO, set `cnt` to 0, go to IDLE.
- **mthi/mtlo:** HI←A or LO←A on the sampling edge; the unit stays in IDLE.
- **Arithmetic**
  - mult: signed 32×32→64.
  - multu: unsigned 32×32→64.
  - In both cases HI = product[63:32] and LO = product[31:0].
  - div: LO = signed quotient, truncated toward zero; HI = remainder, carrying the dividend's sign.
  - divu: unsigned quotient and remainder.
  - 0x80000000 / 0xFFFFFFFF (div) gives LO = 0x80000000, HI = 0.
  - Divide by zero (B == 0): the operation still runs its full 10 cycles, but HI and LO are left unchanged at commit.
- `busy` = (state == BUSY).
- The hazard unit stalls any D-stage HILO instruction while `start | busy`. A `start` received while in BUSY is therefore a protocol violation; it is ignored, with no state, counter or register change.
- `start` with HILOtype 0 has no effect.
- **Reset:** HI = LO = 0, `busy` = 0, state IDLE, `cnt` = 0. Reset during BUSY aborts the operation; the pending result is discarded.

## Timing
- The start edge is edge 0.
- mult/multu
  - `busy` is high from after edge 0 through edge 5.
  - The new HI/LO are visible after edge 5.
- div/divu
  - `busy` is high through edge 10.
  - The new HI/LO are visible after edge 10.
- An instruction issued the cycle after `busy` falls may start immediately: a new start is accepted at edge 6 (mult) or edge 11 (div).
- mthi/mtlo: the new value is visible after edge 0. A following mfhi in E one cycle later reads it.
- `out` is combinational from the current HI/LO with no added latency. During BUSY it reflects the old HI/LO; the stall guarantees it is never consumed in that state.

## Configuration
- Macro `HILO_DELAY_EN`.
- **Defined:** latencies exactly as above.
- **Undefined:**
  - `busy` is tied to 0 and BUSY is never entered.
  - mult/multu/div/divu commit HI/LO directly at the start edge, with the same results and the same divide-by-zero rule.

## Test plan
- Reset, then mult with A=0xFFFFFFFE (−2), B=3: `busy` is high for exactly 5 cycles; then HI=0xFFFFFFFF, LO=0xFFFFFFFA.
- multu with A=0xFFFFFFFF, B=2: HI=0x00000001, LO=0xFFFFFFFE after edge 5.
- div with A=−7 (0xFFFFFFF9), B=2: `busy` is high for 10 cycles; then LO=0xFFFFFFFD, HI=0xFFFFFFFF.
- divu with A=7, B=0 after mthi 0x1234 and mtlo 0x5678: `busy` is high for 10 cycles; HI=0x1234 and LO=0x5678 are unchanged.
- mult started, `reset` asserted at cycle 3: `busy`=0, HI=LO=0 after that edge, with no later commit.
- mtlo A=0xABCD, then mflo the next cycle: `out`=0xABCD. A start pulse during BUSY is ignored and `cnt` keeps counting.
